openram_scan_master: RTL
========================

Name: openram_scan_master

Overview:
Host-side driver for the OpenRAM testchip GPIO scan interface. It takes one parallel SRAM instruction word and shifts it MSB-first into the chip's scan register. It then holds chip-select enabled for a fixed execute window, pulses the SRAM-load strobe, and shifts the captured register back out. The result returns as a parallel response word. It sits in the management/test harness, driving gpio_in, gpio_scan, gpio_sram_load and global_csb, and sampling gpio_out.

Parameters:
TOTAL_SIZE, 112, scan register length (SELECT 4 + 2 ports x 54)
EXEC_CYCLES, 4, cycles global_csb is held low before load (min 1)
IDLE_WORD, 112'h...: all-zero except csb0 (bit 59) and csb1 (bit 5) = 1; word shifted in during readback

Ports:
clk  in  1  clock
resetn  in  1  reset, synchronous, active-low
cmd_valid  in  1  command offered
cmd_ready  out  1  accepting command (IDLE only)
cmd_data  in  TOTAL_SIZE  instruction word, chip register layout
cmd_no_read  in  1  write-only: skip load and readback, no response
rsp_valid  out  1  response available
rsp_ready  in  1  response consumed
rsp_data  out  TOTAL_SIZE  register contents shifted back
rsp_mismatch  out  1  non-data field check failed (feature only, else tied 0)
scan_out  out  1  to chip gpio_in
scan_en  out  1  to chip gpio_scan
sram_load  out  1  to chip gpio_sram_load
scan_in  in  1  from chip gpio_out (register MSB)
csb_hold  out  1  to chip global_csb; 1 blocks all SRAM access
busy  out  1  state != IDLE

Behaviour:
- Reset (resetn low at clk edge, including mid-operation): state IDLE; scan_en=0, sram_load=0, scan_out=0, csb_hold=1, rsp_valid=0, rsp_data=0, rsp_mismatch=0, cmd_ready=1 after release. A partial shift is abandoned. csb_hold=1 keeps the chip safe.
- States: IDLE -> SHIFT_IN -> EXEC -> LOAD -> SHIFT_OUT -> RESP -> IDLE. If cmd_no_read, EXEC goes directly to IDLE.
- IDLE: cmd_ready=1. A cmd_valid&cmd_ready edge latches cmd_data and cmd_no_read into the shift register. The bit counter is loaded with TOTAL_SIZE-1.
- SHIFT_IN: exactly TOTAL_SIZE cycles. scan_en=1 and scan_out=shift_reg[MSB] (registered); shift left each cycle. csb_hold=1 throughout, because transient register contents must not reach the SRAMs. Exit when counter==0.
- EXEC: EXEC_CYCLES cycles, scan_en=0, csb_hold=0.
- LOAD: 1 cycle, sram_load=1, csb_hold=1, scan_en=0. The shift register is reloaded with IDLE_WORD.
- SHIFT_OUT: TOTAL_SIZE cycles, scan_en=1, scan_out=IDLE_WORD MSB-first. Each edge does capture <= {capture[TOTAL_SIZE-2:0], scan_in}. The first sampled bit is the chip MSB (bit 111). The chip ends holding IDLE_WORD, so both ports are deselected.
- RESP: rsp_valid=1 and rsp_data stable until the edge where rsp_ready=1, then IDLE. rsp_ready while rsp_valid=0 is ignored.
- Latency with defaults (accept edge = 0):
  - scan_en high cycles 1..112
  - csb_hold low cycles 113..116
  - sram_load cycle 117
  - scan_en high 118..229
  - rsp_valid from cycle 230
- Counter width: $clog2(TOTAL_SIZE). scan_en and sram_load are never high together.

Optional Feature:
Macro OPENRAM_SCAN_CHECK_EN.
- When defined: in RESP, rsp_mismatch=1 iff the captured word differs from the latched command in any non-data bit. Excluded bits are din0 [91:60] and din1 [37:6].
- When not defined: rsp_mismatch is tied 0 and no command copy is kept.

Decomposition:
- Package openram_scan_pkg:
  - field constants: SELECT_MSB/LSB 111/108; ADDR0 107:92; DIN0 91:60; CSB0 59; WEB0 58; WMASK0 57:54; ADDR1 53:38; DIN1 37:6; CSB1 5; WEB1 4; WMASK1 3:0
  - state enum
  - DATA_MASK constant
- Sub-module openram_scan_shifter: a generic PISO/SIPO shift register with load, shift enable and serial in/out, instantiated once.

Test Plan:
1. Write: cmd_data with select=3, addr0=16'h0010, din0=32'hDEADBEEF, csb0=0, web0=0, wmask0=4'hF, port1 csb1=1. Required response:
   - scan_out bit sequence over cycles 1..112 equals cmd_data[111:0] MSB-first
   - csb_hold low exactly cycles 113..116
   - rsp_valid at cycle 230
2. Readback: same addr with web0=1, chip model returns 32'hDEADBEEF. Required: rsp_data[91:60]=32'hDEADBEEF and all other bits equal to the command.
3. cmd_no_read=1: no sram_load and no SHIFT_OUT; busy falls and cmd_ready rises at cycle 117; rsp_valid never asserts.
4. Backpressure: hold rsp_ready=0 for 20 cycles. Required: rsp_data stable, cmd_ready=0, no scan activity; IDLE on the cycle after rsp_ready=1.
5. Reset asserted at cycle 50 of SHIFT_IN. Required on the next edge: scan_en=0, csb_hold=1, cmd_ready=1 after release; a fresh command then completes normally.
6. OPENRAM_SCAN_CHECK_EN: model flips addr0 bit 92 on readback -> rsp_mismatch=1. Model changes only din0 -> rsp_mismatch=0.

Source files
------------

// File: rtl/openram_scan_pkg.sv
// Shared constants, field layout and state encoding for the OpenRAM testchip scan master.
package openram_scan_pkg;

    localparam int unsigned TOTAL_SIZE = 112;
    localparam int unsigned CNT_W      = $clog2(TOTAL_SIZE);

    localparam int unsigned SELECT_MSB = 111;
    localparam int unsigned SELECT_LSB = 108;
    localparam int unsigned ADDR0_MSB  = 107;
    localparam int unsigned ADDR0_LSB  = 92;
    localparam int unsigned DIN0_MSB   = 91;
    localparam int unsigned DIN0_LSB   = 60;
    localparam int unsigned CSB0       = 59;
    localparam int unsigned WEB0       = 58;
    localparam int unsigned WMASK0_MSB = 57;
    localparam int unsigned WMASK0_LSB = 54;
    localparam int unsigned ADDR1_MSB  = 53;
    localparam int unsigned ADDR1_LSB  = 38;
    localparam int unsigned DIN1_MSB   = 37;
    localparam int unsigned DIN1_LSB   = 6;
    localparam int unsigned CSB1       = 5;
    localparam int unsigned WEB1       = 4;
    localparam int unsigned WMASK1_MSB = 3;
    localparam int unsigned WMASK1_LSB = 0;

    typedef logic [TOTAL_SIZE-1:0] scan_word_t;

    function automatic scan_word_t field_mask(input int unsigned msb, input int unsigned lsb);
        scan_word_t m;
        m = '0;
        for (int unsigned i = lsb; i <= msb; i++) m[i] = 1'b1;
        return m;
    endfunction

    // Data-in fields legitimately change between command and readback
    localparam scan_word_t DATA_MASK = field_mask(DIN0_MSB, DIN0_LSB) | field_mask(DIN1_MSB, DIN1_LSB);
    // Both ports deselected; parked in the chip after every readback
    localparam scan_word_t IDLE_WORD = field_mask(CSB0, CSB0) | field_mask(CSB1, CSB1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SHIFT_IN,
        ST_EXEC,
        ST_LOAD,
        ST_SHIFT_OUT,
        ST_RESP
    } state_e;

endpackage

// File: rtl/openram_scan_shifter.sv
// Parallel-load shift register, MSB-first serial out and LSB serial in.
module openram_scan_shifter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             shift_en,
    input  logic             sin,
    output logic             sout,
    output logic [WIDTH-1:0] data
);

    logic [WIDTH-1:0] data_d;
    logic [WIDTH-1:0] data_q;

    always_comb begin
        data_d = data_q;
        if (load) begin
            data_d = load_data;
        end else if (shift_en) begin
            data_d = {data_q[WIDTH-2:0], sin};
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign sout = data_q[WIDTH-1];
    assign data = data_q;

endmodule

// File: rtl/openram_scan_master.sv
// Host-side scan driver for the OpenRAM testchip: shift in, execute, load, shift out, respond.
// Optional OPENRAM_SCAN_CHECK_EN compares non-data bits of the readback against the command.
module openram_scan_master
    import openram_scan_pkg::*;
#(
    parameter int unsigned EXEC_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [TOTAL_SIZE-1:0] cmd_data,
    input  logic                  cmd_no_read,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [TOTAL_SIZE-1:0] rsp_data,
    output logic                  rsp_mismatch,
    output logic                  scan_out,
    output logic                  scan_en,
    output logic                  sram_load,
    input  logic                  scan_in,
    output logic                  csb_hold,
    output logic                  busy
);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               no_read_q, no_read_d;
    logic               scan_en_q, scan_en_d;
    logic               sram_load_q, sram_load_d;
    logic               csb_hold_q, csb_hold_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic               cmd_ready_q, cmd_ready_d;
    logic               busy_q, busy_d;
    logic               accept;
    logic               sh_load;
    scan_word_t         sh_load_data;
    scan_word_t         sh_data;

    assign accept = cmd_valid && cmd_ready_q;

    // Pin outputs track the state one cycle late, so shifting is aligned to the registered scan_en
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        no_read_d    = no_read_q;
        sh_load      = 1'b0;
        sh_load_data = cmd_data;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d   = ST_SHIFT_IN;
                    cnt_d     = CNT_W'(TOTAL_SIZE - 1);
                    no_read_d = cmd_no_read;
                    sh_load   = 1'b1;
                end
            end
            ST_SHIFT_IN: begin
                if (cnt_q == '0) begin
                    state_d = ST_EXEC;
                    cnt_d   = CNT_W'(EXEC_CYCLES - 1);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_EXEC: begin
                if (cnt_q == '0) begin
                    state_d = no_read_q ? ST_IDLE : ST_LOAD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_LOAD: begin
                state_d      = ST_SHIFT_OUT;
                cnt_d        = CNT_W'(TOTAL_SIZE - 1);
                sh_load      = 1'b1;
                sh_load_data = IDLE_WORD;
            end
            ST_SHIFT_OUT: begin
                if (cnt_q == '0) begin
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_RESP: begin
                if (rsp_valid_q && rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        scan_en_d   = (state_q == ST_SHIFT_IN) || (state_q == ST_SHIFT_OUT);
        sram_load_d = (state_q == ST_LOAD);
        csb_hold_d  = (state_q != ST_EXEC);
        rsp_valid_d = (state_q == ST_RESP) && (state_d == ST_RESP);
        cmd_ready_d = (state_q == ST_IDLE) && (state_d == ST_IDLE);
        busy_d      = !cmd_ready_d;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            no_read_q   <= 1'b0;
            scan_en_q   <= 1'b0;
            sram_load_q <= 1'b0;
            csb_hold_q  <= 1'b1;
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            no_read_q   <= no_read_d;
            scan_en_q   <= scan_en_d;
            sram_load_q <= sram_load_d;
            csb_hold_q  <= csb_hold_d;
            rsp_valid_q <= rsp_valid_d;
            cmd_ready_q <= cmd_ready_d;
            busy_q      <= busy_d;
        end
    end

    // One register serves as outgoing word and capture; the chip shifts on the same edges
    openram_scan_shifter #(
        .WIDTH (TOTAL_SIZE)
    ) u_shifter (
        .clk       (clk),
        .resetn    (resetn),
        .load      (sh_load),
        .load_data (sh_load_data),
        .shift_en  (scan_en_q),
        .sin       (scan_in),
        .sout      (scan_out),
        .data      (sh_data)
    );

`ifdef OPENRAM_SCAN_CHECK_EN
    scan_word_t cmd_copy_q, cmd_copy_d;
    scan_word_t cap_next;
    logic       rsp_mismatch_q, rsp_mismatch_d;

    // Judge the word as it will stand after this edge, so the flag appears with rsp_valid
    always_comb begin
        cmd_copy_d = cmd_copy_q;
        if ((state_q == ST_IDLE) && accept) begin
            cmd_copy_d = cmd_data;
        end
        cap_next       = scan_en_q ? {sh_data[TOTAL_SIZE-2:0], scan_in} : sh_data;
        rsp_mismatch_d = rsp_valid_d && (|((cap_next ^ cmd_copy_q) & ~DATA_MASK));
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            cmd_copy_q     <= '0;
            rsp_mismatch_q <= 1'b0;
        end else begin
            cmd_copy_q     <= cmd_copy_d;
            rsp_mismatch_q <= rsp_mismatch_d;
        end
    end

    assign rsp_mismatch = rsp_mismatch_q;
`else
    assign rsp_mismatch = 1'b0;
`endif

    assign rsp_data  = sh_data;
    assign scan_en   = scan_en_q;
    assign sram_load = sram_load_q;
    assign csb_hold  = csb_hold_q;
    assign rsp_valid = rsp_valid_q;
    assign cmd_ready = cmd_ready_q;
    assign busy      = busy_q;

endmodule
